// File: rtl/pk_decode_pkg.sv
// Shared definitions for the pk_decode path.
// Contents: bitlen() helper, unpack-mode enum, ML-DSA constants (q, d, eta and gamma1 sets).
package pk_decode_pkg;

  typedef enum logic {
    SIMPLE = 1'b0,  // w = z
    SIGNED = 1'b1   // w = B - z
  } unpack_mode_e;

  localparam int unsigned MLDSA_Q = 8380417;
  localparam int unsigned MLDSA_D = 13;
  localparam int unsigned ETA_SET [2] = '{2, 4};
  localparam int unsigned GAMMA1_SET [2] = '{32'd1 << 17, 32'd1 << 19};

  // Number of bits needed to hold v; a zero-valued bound still occupies one bit.
  function automatic int unsigned bitlen(input int unsigned v);
    int unsigned n;
    n = 1;
    for (int i = 1; i < 32; i++) begin
      if (v >= (32'd1 << i)) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bit_unpack_stream_if.sv
// Handshake bundle for bit_unpack_stream.
// Input side: in_valid/in_ready/in_data/in_last. Output side: out_valid/out_ready/out_coef/
// out_last/out_err, plus the len_err framing pulse. The slave modport is the unpacker's view.
interface bit_unpack_stream_if #(
  parameter int unsigned IN_BYTES = 4,
  parameter int unsigned LANES    = 4,
  parameter int unsigned COEF_W   = 24
);
  import pk_decode_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [8*IN_BYTES-1:0]     in_data;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*COEF_W-1:0]   out_coef;
  logic                      out_last;
  logic                      out_err;
  logic                      len_err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_coef, out_last, out_err, len_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_coef, out_last, out_err, len_err
  );

endinterface

// File: rtl/bit_unpack_acc.sv
// Bit accumulator for the stream unpacker.
// i_push appends i_data at the current fill position, i_pop drops the low LANE_BITS bits,
// i_clear empties everything (dominates). o_in_ready / o_out_valid derive from the registered
// fill only; o_lane_bits exposes the bits of the next output beat.
module bit_unpack_acc #(
  parameter int unsigned LANE_BITS = 40,
  parameter int unsigned IN_W      = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic [IN_W-1:0]      i_data,
  output logic                 o_in_ready,
  output logic                 o_out_valid,
  output logic [LANE_BITS-1:0] o_lane_bits
);

  localparam int unsigned ACC_W  = LANE_BITS + IN_W;
  localparam int unsigned FILL_W = $clog2(ACC_W + 1);
  localparam logic [FILL_W-1:0] LaneFill = FILL_W'(LANE_BITS);
  localparam logic [FILL_W-1:0] InFill   = FILL_W'(IN_W);

  logic [ACC_W-1:0]  r_acc, w_acc_shift, w_acc_next;
  logic [FILL_W-1:0] r_fill, w_fill_shift, w_fill_next;

  // Pop is applied first so a same-cycle push lands right above the surviving bits.
  always_comb begin
    w_acc_shift  = r_acc;
    w_fill_shift = r_fill;
    if (i_pop) begin
      w_acc_shift  = r_acc >> LANE_BITS;
      w_fill_shift = r_fill - LaneFill;
    end
    w_acc_next  = w_acc_shift;
    w_fill_next = w_fill_shift;
    if (i_push) begin
      w_acc_next  = w_acc_shift | (ACC_W'(i_data) << w_fill_shift);
      w_fill_next = w_fill_shift + InFill;
    end
    if (i_clear) begin
      w_acc_next  = '0;
      w_fill_next = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc  <= '0;
      r_fill <= '0;
    end else begin
      r_acc  <= w_acc_next;
      r_fill <= w_fill_next;
    end
  end

  // fill + IN_W <= ACC_W reduces to fill <= LANE_BITS.
  assign o_in_ready  = (r_fill <= LaneFill);
  assign o_out_valid = (r_fill >= LaneFill);
  assign o_lane_bits = r_acc[LANE_BITS-1:0];

endmodule

// File: rtl/bit_unpack_stream.sv
// Streaming polynomial bit-unpacker (SimpleBitUnpack / BitUnpack).
// Ports: i_clk, i_rst_n (async active-low), bus (slave modport of bit_unpack_stream_if) carrying
// the packed-byte input stream and the LANES-wide signed coefficient output stream.
// Holds the beat counters, framing check, per-lane arithmetic and range check.
module bit_unpack_stream
  import pk_decode_pkg::*;
#(
  parameter int unsigned MODE     = 0,
  parameter int unsigned A        = 0,
  parameter int unsigned B        = 1023,
  parameter int unsigned LANES    = 4,
  parameter int unsigned IN_BYTES = 4,
  parameter int unsigned COEF_W   = 24
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  bit_unpack_stream_if.slave     bus
);

  localparam unpack_mode_e Mode = (MODE != 0) ? SIGNED : SIMPLE;
  localparam int unsigned MAX_Z      = (Mode == SIGNED) ? A + B : B;
  localparam int unsigned C          = bitlen(MAX_Z);
  localparam int unsigned LANE_BITS  = LANES * C;
  localparam int unsigned IN_W       = 8 * IN_BYTES;
  localparam int unsigned POLY_BEATS = 32 * C / IN_BYTES;
  localparam int unsigned OUT_BEATS  = 256 / LANES;
  localparam int unsigned IN_CNT_W   = (POLY_BEATS > 1) ? $clog2(POLY_BEATS) : 1;
  localparam int unsigned OUT_CNT_W  = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
  localparam logic [IN_CNT_W-1:0]  InCntMax  = IN_CNT_W'(POLY_BEATS - 1);
  localparam logic [OUT_CNT_W-1:0] OutCntMax = OUT_CNT_W'(OUT_BEATS - 1);
  // One spare bit keeps the range compare meaningful when MAX_Z is all-ones in C bits.
  localparam logic [C:0]          ZMax  = (C + 1)'(MAX_Z);
  localparam logic [COEF_W-1:0]   BCoef = COEF_W'(B);

  logic                    w_in_ready, w_out_valid;
  logic [LANE_BITS-1:0]    w_lane_bits;
  logic                    w_in_fire, w_out_fire, w_final_beat, w_early_last, w_push, w_out_last;
  logic [IN_CNT_W-1:0]     r_in_cnt;
  logic [OUT_CNT_W-1:0]    r_out_cnt;
  logic                    r_len_err;
  logic [LANES*COEF_W-1:0] w_coef;
  logic                    w_err;
  logic [C:0]              w_z;

  assign w_in_fire    = bus.in_valid & w_in_ready;
  assign w_out_fire   = w_out_valid & bus.out_ready;
  assign w_final_beat = (r_in_cnt == InCntMax);
  // A premature in_last aborts the polynomial; the beat itself is dropped.
  assign w_early_last = w_in_fire & bus.in_last & ~w_final_beat;
  assign w_push       = w_in_fire & ~w_early_last;
  assign w_out_last   = (r_out_cnt == OutCntMax);

  bit_unpack_acc #(
    .LANE_BITS (LANE_BITS),
    .IN_W      (IN_W)
  ) u_acc (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (w_early_last),
    .i_push      (w_push),
    .i_pop       (w_out_fire),
    .i_data      (bus.in_data),
    .o_in_ready  (w_in_ready),
    .o_out_valid (w_out_valid),
    .o_lane_bits (w_lane_bits)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_len_err <= 1'b0;
    end else begin
      // Flags both an early in_last and a missing in_last on the final beat.
      r_len_err <= w_in_fire & (bus.in_last ^ w_final_beat);
      if (w_early_last) begin
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_in_fire)  r_in_cnt  <= w_final_beat ? '0 : r_in_cnt + 1'b1;
        if (w_out_fire) r_out_cnt <= w_out_last ? '0 : r_out_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_coef = '0;
    w_err  = 1'b0;
    w_z    = '0;
    for (int j = 0; j < LANES; j++) begin
      w_z = {1'b0, w_lane_bits[j*C +: C]};
      if (Mode == SIGNED) w_coef[j*COEF_W +: COEF_W] = BCoef - COEF_W'(w_z);
      else                w_coef[j*COEF_W +: COEF_W] = COEF_W'(w_z);
      if (w_z > ZMax) w_err = 1'b1;
    end
  end

  // Outputs are forced to zero while no beat is offered, so idle/reset values read as 0.
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_coef  = w_out_valid ? w_coef : '0;
  assign bus.out_last  = w_out_valid & w_out_last;
  assign bus.out_err   = w_out_valid & w_err;
  assign bus.len_err   = r_len_err;

endmodule

// File: doc/bit_unpack_stream.md
# bit_unpack_stream

Streaming, parametrised polynomial bit-unpacker for the pk_decode path. It covers FIPS 204 SimpleBitUnpack (t1, w = z) and BitUnpack (η, γ1 fields, w = B − z) in one block. It takes a packed byte stream over a valid/ready input, emits LANES signed coefficients per beat over a valid/ready output, and checks polynomial framing and coefficient range. It replaces whole-polynomial parallel unpacking ahead of NTT/storage.

## Interface
- MODE, default 0: 0 = simple (w = z, legal z ≤ B); 1 = signed (w = B − z, legal z ≤ A+B).
- A, default 0: lower bound magnitude; used only when MODE = 1.
- B, default 1023: upper bound.
- LANES, default 4: coefficients per output beat; must divide 256.
- IN_BYTES, default 4: bytes per input beat; must divide 32·C.
- COEF_W, default 24: signed output coefficient width.
- Derived: C = bitlen(MODE ? A+B : B), where bitlen(0) = 1; POLY_BEATS = 32·C / IN_BYTES; OUT_BEATS = 256 / LANES; ACC_W = LANES·C + 8·IN_BYTES.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when high with in_valid.
- in_data  in  8·IN_BYTES  packed bytes; byte k is in_data[8k +: 8] and is earlier in the stream than byte k+1.
- in_last  in  1  final beat of a polynomial.
- out_valid  out  1  coefficient beat valid.
- out_ready  in  1  downstream accept.
- out_coef  out  LANES×COEF_W  signed coefficients; lane j is coefficient index base+j.
- out_last  out  1  beat carrying coefficient 255.
- out_err  out  1  at least one lane in this beat had z out of the legal range.
- len_err  out  1  one-cycle pulse on a framing violation.

## Operation
- Bit order: the stream is little-endian. The first byte received supplies bits 0..7. Coefficient i is z = bits[i·C +: C].
- Accumulator: ACC_W-bit register plus a fill count.
  - An accepted input beat is appended at bit position fill.
  - A fired output beat removes the low LANES·C bits and shifts the remainder down.
  - Append and remove in the same cycle are both applied: fill' = fill + 8·IN_BYTES − LANES·C.
- in_ready = (fill + 8·IN_BYTES ≤ ACC_W), using the registered fill only.
- out_valid = (fill ≥ LANES·C), using the registered fill only.
- out_coef lane j:
  - MODE 0: zero-extended z.
  - MODE 1: B − z, sign-extended to COEF_W.
  - An out-of-range coefficient is still output as computed, and out_err is asserted for that beat.
- Counters:
  - in_cnt, 0..POLY_BEATS−1, advances on each input fire.
  - out_cnt, 0..OUT_BEATS−1, advances on each output fire. out_last = (out_cnt == OUT_BEATS−1). Both counters wrap to 0 at end of polynomial.
- Framing:
  - in_last on a beat where in_cnt < POLY_BEATS−1: pulse len_err, discard that beat, clear the accumulator, fill and both counters. Output already emitted stands.
  - A beat at in_cnt == POLY_BEATS−1 without in_last: pulse len_err, but treat the beat as final. The polynomial completes normally.
- Back-to-back polynomials need no idle cycle.

## Timing
- Reset values: in_ready 1 (after release), out_valid 0, out_coef 0, out_last 0, out_err 0, len_err 0, fill 0, both counters 0.
- Latency: the first output beat is valid in the cycle after the input fire that makes fill ≥ LANES·C. There is no combinational path from in_valid or out_ready to any output.
- Output hold: out_coef, out_last and out_err are stable while out_valid && !out_ready.
- Reset asserted mid-polynomial: all state clears immediately. The partial polynomial is lost, and no len_err is raised.

## Structure
- Shared package pk_decode_pkg holds:
  - the bitlen() function;
  - the unpack-mode enum (SIMPLE, SIGNED);
  - the ML-DSA constants q, d, and the η and γ1 sets.
- Sub-module bit_unpack_acc holds the accumulator, fill, append/shift logic and the in_ready/out_valid derivation.
- The top level holds the counters, framing logic, lane arithmetic and range check.

## Test plan
- Reset: hold reset low for 3 cycles, then release. Expect all outputs 0, in_ready = 1, and no output until input is driven.
- MODE 0, B = 1023, defaults: stream 320 bytes repeating 01 04 10 40 00 with out_ready = 1. Expect 64 beats of {1,1,1,1}, out_last only on beat 63, out_err = 0.
- MODE 1, A = B = 2 (C = 3): drive 96 zero bytes, then 96 bytes with byte 0 = 0x07.
  - Zero bytes: all coefficients = 2.
  - Second polynomial, beat 0: lane 0 = −5 with out_err = 1; lanes 1–3 = 2.
- Backpressure: hold out_ready low for 10 cycles mid-polynomial. Expect in_ready to drop once fill > ACC_W − 32, no data lost or duplicated, and order identical to the free-running run.
- Framing:
  - in_last on input beat 50 of 80: one-cycle len_err, and the next polynomial decodes correctly from its first byte.
  - Beat 79 without in_last: len_err pulse and out_last still asserted.
- Reset mid-stream: assert reset after output beat 20. Expect immediate clear. A subsequent full polynomial decodes correctly with out_last on beat 63.
